// File: rtl/calc_display_pkg.sv
// calc_display_pkg: shared states, 7-segment glyphs and the BCD adjust helper
package calc_display_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONVERT = 3'd1,
        FORMAT  = 3'd2,
        SHIFT   = 3'd3,
        LATCH   = 3'd4
    } state_t;

    localparam logic [7:0] SEG_FONT [0:15] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_MINUS = 8'h40;
    localparam logic [7:0] SEG_E     = 8'h79;
    localparam logic [7:0] SEG_R     = 8'h50;

    function automatic logic [3:0] dd_adj(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one input bit per cycle, sticky overflow
module bin2bcd_seq
    import calc_display_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     data,
    output logic                      done,
    output logic [(NUM_DIGITS+1)*4-1:0] bcd,
    output logic                      ovf
);

    localparam int BW = (NUM_DIGITS + 1) * 4;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] bin;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         adj;

    // done marks the cycle whose edge performs the final shift
    assign done = (cnt == CW'(1));

    // add-3 correction on every digit before the shift
    always_comb begin
        adj = '0;
        for (int i = 0; i < NUM_DIGITS + 1; i++) adj[i*4 +: 4] = dd_adj(bcd[i*4 +: 4]);
    end

    // shift one binary bit into the BCD accumulator per cycle; a carry out of the top digit is sticky
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin <= '0;
            bcd <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            bin <= data;
            bcd <= '0;
            ovf <= 1'b0;
            cnt <= CW'(DATA_WIDTH);
        end else if (cnt != '0) begin
            bcd <= {adj[BW-2:0], bin[DATA_WIDTH-1]};
            ovf <= ovf | adj[BW-1];
            bin <= bin << 1;
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/sr_display_driver.sv
// sr_display_driver: converts a signed magnitude to 7-seg digits and shifts them into chained 595s
module sr_display_driver
    import calc_display_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DIGITS = 5,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_is_neg,
    input  logic                  i_error,
    input  logic                  i_hex,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_sr_data,
    output logic                  o_sr_clk,
    output logic                  o_sr_latch,
    output logic                  o_sr_oe_n
);

    localparam int HN    = (DATA_WIDTH + 3) / 4;
    localparam int MD    = (HN > NUM_DIGITS + 1) ? HN : NUM_DIGITS + 1;
    localparam int SW    = MD * 4;
    localparam int FW    = 8 * NUM_DIGITS;
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(FW);

    state_t                      state;
    logic [DATA_WIDTH-1:0]       data_q;
    logic                        neg_q, err_q, hex_q;
    logic [(NUM_DIGITS+1)*4-1:0] bcd;
    logic                        bcd_ovf, bcd_done, bcd_start;
    logic [SW-1:0]               src;
    logic [FW-1:0]               frame, sreg;
    logic [DIV_W-1:0]            div_cnt;
    logic [BIT_W-1:0]            bit_cnt;
    logic                        ovf;
    int                          msd, need;

    assign o_ready   = (state == IDLE);
    assign o_sr_data = sreg[FW-1];
    assign bcd_start = i_valid && o_ready && !i_error && !i_hex;

    bin2bcd_seq #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_DIGITS(NUM_DIGITS)
    ) u_bcd (
        .clk  (clk),
        .rst_n(rst_n),
        .start(bcd_start),
        .data (i_data),
        .done (bcd_done),
        .bcd  (bcd),
        .ovf  (bcd_ovf)
    );

    // frame builder: blanking, sign placement, overflow dashes and error text
    always_comb begin
        src   = hex_q ? SW'(data_q) : SW'(bcd);
        msd   = 0;
        frame = '0;
        for (int i = 0; i < MD; i++) if (src[i*4 +: 4] != 4'd0) msd = i;
        need = msd + 1 + (neg_q ? 1 : 0);
        ovf  = (need > NUM_DIGITS) || (!hex_q && bcd_ovf);
        for (int i = 0; i < NUM_DIGITS; i++)
            frame[i*8 +: 8] = err_q ? ((NUM_DIGITS < 3) ? SEG_E : (i == 2) ? SEG_E : (i < 2) ? SEG_R : SEG_BLANK)
                            : ovf ? SEG_MINUS
                            : (i <= msd) ? SEG_FONT[src[i*4 +: 4]]
                            : (neg_q && i == msd + 1) ? SEG_MINUS : SEG_BLANK;
    end

    // request capture, conversion wait, then bit-serial shift and latch pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            data_q     <= '0;
            neg_q      <= 1'b0;
            err_q      <= 1'b0;
            hex_q      <= 1'b0;
            sreg       <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            o_sr_clk   <= 1'b0;
            o_sr_latch <= 1'b0;
            o_sr_oe_n  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    data_q <= i_data;
                    neg_q  <= i_data_is_neg;
                    err_q  <= i_error;
                    hex_q  <= i_hex;
                    state  <= i_error ? FORMAT : CONVERT;
                end
                CONVERT: if (hex_q || bcd_done) state <= FORMAT;
                FORMAT: begin
                    sreg     <= frame;
                    div_cnt  <= '0;
                    bit_cnt  <= '0;
                    o_sr_clk <= 1'b0;
                    state    <= SHIFT;
                end
                SHIFT: if (div_cnt != DIV_W'(CLK_DIV - 1)) div_cnt <= div_cnt + DIV_W'(1);
                else begin
                    div_cnt <= '0;
                    if (!o_sr_clk) o_sr_clk <= 1'b1;
                    else begin
                        o_sr_clk <= 1'b0;
                        if (bit_cnt == BIT_W'(FW - 1)) begin
                            o_sr_latch <= 1'b1;
                            state      <= LATCH;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            sreg    <= {sreg[FW-2:0], 1'b0};
                        end
                    end
                end
                LATCH: if (div_cnt != DIV_W'(CLK_DIV - 1)) div_cnt <= div_cnt + DIV_W'(1);
                else begin
                    div_cnt    <= '0;
                    o_sr_latch <= 1'b0;
                    o_sr_oe_n  <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
